// File: rtl/seg_msg_pkg.sv
// Shared character codes, glyphs, FSM states and mode encodings for the
// 7-segment message sequencer.
package seg_msg_pkg;

    // Character codes held in the message buffer
    typedef enum logic [2:0] {
        CH_BLANK,
        CH_N,
        CH_O,
        CH_P,
        CH_E,
        CH_I,
        CH_C
    } char_t;

    // Active-low glyphs, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_N     = 7'b1101010;
    localparam logic [6:0] GLYPH_O     = 7'b0000001;
    localparam logic [6:0] GLYPH_P     = 7'b0011000;
    localparam logic [6:0] GLYPH_E     = 7'b0110000;
    localparam logic [6:0] GLYPH_I     = 7'b1111001;
    localparam logic [6:0] GLYPH_C     = 7'b0110001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STATIC,
        ST_BLINK_ON,
        ST_BLINK_OFF,
        ST_SCROLL
    } state_t;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_SCROLL = 2'b10;

    // Initial display state for a mode; 2'b11 falls back to static
    function automatic state_t mode_entry(input logic [1:0] m);
        state_t s;
        case (m)
            MODE_BLINK:  s = ST_BLINK_ON;
            MODE_SCROLL: s = ST_SCROLL;
            default:     s = ST_STATIC;
        endcase
        return s;
    endfunction

    // Character i (0..3) of the word: sel=0 "NOPE", sel=1 "NICE"
    function automatic char_t word_char(input logic sel, input logic [1:0] i);
        char_t c;
        case (i)
            2'd0:    c = CH_N;
            2'd1:    c = sel ? CH_I : CH_O;
            2'd2:    c = sel ? CH_C : CH_P;
            default: c = CH_E;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seg_char_rom.sv
// Combinational character-code to active-low 7-segment glyph lookup.
module seg_char_rom
    import seg_msg_pkg::*;
(
    input  char_t      code,
    output logic [6:0] glyph
);

    // Pure lookup; unknown codes render blank
    always_comb begin
        glyph = GLYPH_BLANK;
        case (code)
            CH_N:    glyph = GLYPH_N;
            CH_O:    glyph = GLYPH_O;
            CH_P:    glyph = GLYPH_P;
            CH_E:    glyph = GLYPH_E;
            CH_I:    glyph = GLYPH_I;
            CH_C:    glyph = GLYPH_C;
            default: glyph = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_message_sequencer.sv
// Drives a NOPE/NICE message onto NUM_DIGITS 7-segment digits in static,
// blink or scroll mode, paced by a TICK_DIV-cycle display tick.
module seg_message_sequencer
    import seg_msg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MSG_LEN    = 8,
    parameter int unsigned TICK_DIV   = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in,
    input  logic                    enable,
    input  logic [1:0]              mode,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    busy
);

    localparam int unsigned PW = $clog2(MSG_LEN);
    localparam int unsigned CW = $clog2(TICK_DIV);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic            in_q, in_d;
    logic [1:0]      mode_q, mode_d;
    logic            tick;

    char_t           chars [NUM_DIGITS];
    logic [6:0]      glyph [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] seg_d;

    // (p + k) mod MSG_LEN by one conditional subtract: p < MSG_LEN and
    // k < NUM_DIGITS <= MSG_LEN keep the sum below 2*MSG_LEN
    function automatic int unsigned wrap_idx(input int unsigned p, input int unsigned k);
        int unsigned s;
        s = p + k;
        return (s >= MSG_LEN) ? s - MSG_LEN : s;
    endfunction

    // Next-state: enable low forces IDLE; restart beats tick; otherwise count and advance
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        in_d    = in_q;
        mode_d  = mode_q;
        tick    = (cnt_q == CW'(TICK_DIV - 1));
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pos_d   = '0;
        end else if (state_q == ST_IDLE || in != in_q || mode != mode_q) begin
            in_d    = in;
            mode_d  = mode;
            cnt_d   = '0;
            pos_d   = '0;
            state_d = mode_entry(mode);
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                case (state_q)
                    ST_BLINK_ON:  state_d = ST_BLINK_OFF;
                    ST_BLINK_OFF: state_d = ST_BLINK_ON;
                    ST_SCROLL:    pos_d = (pos_q == PW'(MSG_LEN - 1)) ? '0 : pos_q + 1'b1;
                    default:      ;
                endcase
            end
        end
    end

    // Per-digit character selection from the next state so seg lands with it
    always_comb begin
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            int unsigned idx;
            idx      = wrap_idx(32'(pos_d), k);
            chars[k] = CH_BLANK;
            if ((state_d == ST_STATIC || state_d == ST_BLINK_ON || state_d == ST_SCROLL)
                && idx < 4) begin
                chars[k] = word_char(in_d, idx[1:0]);
            end
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        seg_char_rom u_rom (
            .code  (chars[k]),
            .glyph (glyph[k])
        );
    end

    // Pack digit 0 into the most significant slot
    always_comb begin
        seg_d = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            seg_d[7*(NUM_DIGITS-1-k) +: 7] = glyph[k];
        end
    end

    // State, counters, latched inputs and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            in_q    <= 1'b0;
            mode_q  <= MODE_STATIC;
            seg     <= '1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            in_q    <= in_d;
            mode_q  <= mode_d;
            seg     <= seg_d;
            busy    <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_seg_message_sequencer.sv
// Scoreboard bench: a behavioural model computes the expected display from
// the time since the last restart; a monitor compares on every falling edge.
module tb_seg_message_sequencer;

    localparam int ND = 4;
    localparam int ML = 8;
    localparam int TD = 4;

    typedef struct {
        logic [7*ND-1:0] seg;
        logic            busy;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            in_b;
    logic            enable;
    logic [1:0]      mode_b;
    logic [7*ND-1:0] seg;
    logic            busy;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 0;

    // model state
    bit         m_idle = 1;
    logic       m_in   = 0;
    logic [1:0] m_mode = 0;
    int         m_j    = 0;

    logic [6:0] nope_w [4] = '{7'b1101010, 7'b0000001, 7'b0011000, 7'b0110000};
    logic [6:0] nice_w [4] = '{7'b1101010, 7'b1111001, 7'b0110001, 7'b0110000};
    localparam logic [6:0] BLANK = 7'b1111111;

    seg_message_sequencer #(
        .NUM_DIGITS (ND),
        .MSG_LEN    (ML),
        .TICK_DIV   (TD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in_b),
        .enable (enable),
        .mode   (mode_b),
        .seg    (seg),
        .busy   (busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] buf_char(input int i);
        if (i >= 4) return BLANK;
        return m_in ? nice_w[i] : nope_w[i];
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   ticks;
        e.seg  = '1;
        e.busy = 0;
        if (!m_idle) begin
            e.busy = 1;
            ticks  = m_j / TD;
            for (int k = 0; k < ND; k++) begin
                logic [6:0] g;
                if (m_mode == 2'b01)      g = (ticks % 2 == 1) ? BLANK : buf_char(k);
                else if (m_mode == 2'b10) g = buf_char((ticks + k) % ML);
                else                      g = buf_char(k);
                e.seg[7*(ND-1-k) +: 7] = g;
            end
        end
        return e;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_idle = 1; m_in = 0; m_mode = 0; m_j = 0;
        end else if (!enable) begin
            m_idle = 1;
        end else if (m_idle || in_b != m_in || mode_b != m_mode) begin
            m_idle = 0; m_in = in_b; m_mode = mode_b; m_j = 0;
        end else begin
            m_j++;
        end
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            q.push_back(model_out());
            #1;
        end
    endtask

    // Monitor: one expected entry per cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
                end else begin
                    e = q.pop_front();
                    if (seg !== e.seg) begin
                        errors++;
                        $display("FAIL seg at %0t: got %07h want %07h", $time, seg, e.seg);
                    end
                    checks++;
                    if (busy !== e.busy) begin
                        errors++;
                        $display("FAIL busy at %0t: got %0b want %0b", $time, busy, e.busy);
                    end
                end
            end
        end
    end

    initial begin
        exp_t blank_e;
        blank_e.seg  = '1;
        blank_e.busy = 0;

        reset = 1; enable = 1; in_b = 0; mode_b = 2'b00;
        mon_on = 1;
        edges(2);

        checks++;
        if (seg !== 28'h0FFFFFFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: seg=%07h busy=%0b want 0FFFFFFF/0", seg, busy);
        end

        // static NOPE
        reset = 0; in_b = 0; mode_b = 2'b00;
        edges(40);
        // blink NICE
        in_b = 1; mode_b = 2'b01;
        edges(24);
        // scroll NOPE through a full wrap
        in_b = 0; mode_b = 2'b10;
        edges(36);
        // word change coinciding with a tick edge
        for (int g = 0; g < 8 && (m_j % TD) != TD - 1; g++) edges(1);
        in_b = 1;
        edges(12);
        // blink, drop enable while off
        mode_b = 2'b01;
        edges(5);
        enable = 0;
        edges(3);
        enable = 1;
        edges(6);
        // scroll then asynchronous reset between edges
        in_b = 0; mode_b = 2'b10;
        edges(13);
        #2;
        reset = 1;
        #1;
        checks++;
        if (seg !== 28'h0FFFFFFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: seg=%07h busy=%0b want 0FFFFFFF/0", seg, busy);
        end
        q.delete();
        q.push_back(blank_e);
        m_idle = 1; m_in = 0; m_mode = 0; m_j = 0;
        edges(2);
        reset = 0;
        edges(20);

        // randomized phase
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) in_b = ~in_b;
            if ($urandom_range(0, 15) == 0) mode_b = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) enable = ~enable;
            edges(1);
        end

        @(negedge clk);
        #1;
        mon_on = 0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_message_sequencer.md
SEG_MESSAGE_SEQUENCER -- requirements
Module: seg_message_sequencer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of 7-segment digits driven; legal range 1..8.
REQ-002 SHALL have parameter MSG_LEN, default 8: message buffer length in characters; SHALL be >= NUM_DIGITS and >= 4.
REQ-003 SHALL have parameter TICK_DIV, default 25_000_000: clk cycles per display tick (0.5 s at 50 MHz); SHALL be >= 2.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in  input  1  result bit; 0 selects word "NOPE", 1 selects word "NICE".
REQ-007 enable  input  1  level; 1 = display active, 0 = all digits blank.
REQ-008 mode  input  2  00 static, 01 blink, 10 scroll, 11 treated as static.
REQ-009 seg  output  7*NUM_DIGITS  registered, active-low segments (0 = segment lit); digit 0 (leftmost) in seg[7*NUM_DIGITS-1 -: 7]; bit order per digit {a,b,c,d,e,f,g}, a in MSB.
REQ-010 busy  output  1  registered; 1 whenever the FSM is outside IDLE.

Function
REQ-011 Buffer: characters 0..3 = selected word, characters 4..MSG_LEN-1 = blank.
REQ-012 Glyphs: N=1101010, O=0000001, P=0011000, E=0110000, I=1111001, C=0110001, blank=1111111.
REQ-013 FSM states: IDLE, STATIC, BLINK_ON, BLINK_OFF, SCROLL.
REQ-014 IDLE -> STATIC/BLINK_ON/SCROLL (per mode) on the first edge with enable=1; any state -> IDLE on the edge where enable=0.
REQ-015 Restart: entering from IDLE, or a change in in or mode while enabled, SHALL latch in/mode, clear tick counter and scroll position, and enter the mode's initial state on that edge.
REQ-016 Latency: seg SHALL reflect a new state/word one cycle after the sampling edge (registered output).
REQ-017 Tick counter SHALL count 0..TICK_DIV-1, pulse tick at TICK_DIV-1, wrap to 0; held at 0 in IDLE.
REQ-018 STATIC: digit k shows buffer[k]; tick ignored.
REQ-019 BLINK: BLINK_ON shows as STATIC, BLINK_OFF blanks all digits; toggle on each tick.
REQ-020 SCROLL: digit k shows buffer[(pos+k) mod MSG_LEN]; pos increments on each tick, wraps MSG_LEN-1 -> 0.
REQ-021 IDLE: all digits blank (all ones), busy=0.
REQ-022 Restart and tick on the same edge: restart wins; counter and pos cleared, no advance.
REQ-023 enable falling on a tick edge: IDLE wins; pos not advanced.
REQ-024 Width rules: pos is clog2(MSG_LEN) bits, counter is clog2(TICK_DIV) bits; mod computed without overflow for all legal parameters.

Reset
REQ-025 On reset asserted SHALL asynchronously force FSM=IDLE, counter=0, pos=0, latched in/mode=0, seg all ones, busy=0.
REQ-026 Reset mid-tick or mid-scroll SHALL discard progress; after release, restart per REQ-014 if enable=1.

Structure
REQ-027 Package seg_msg_pkg SHALL hold the character-code enum (BLANK,N,O,P,E,I,C), 7-bit glyph constants, FSM state typedef and mode constants.
REQ-028 Sub-module seg_char_rom SHALL map one character code to one 7-bit glyph, combinationally; instantiated NUM_DIGITS times.

Verification (TICK_DIV=4, NUM_DIGITS=4, MSG_LEN=8)
REQ-029 reset=1, enable=1 -> seg=0x0FFFFFFF, busy=0; release, in=0, mode=00 -> next cycle seg=1101010_0000001_0011000_0110000, held 40 cycles.
REQ-030 in=1, mode=01 -> NICE for 4 cycles, all blank 4 cycles, repeating; busy=1 throughout.
REQ-031 in=0, mode=10 -> after 1 tick "OPE_", after 4 ticks all blank, after 8 ticks "NOPE" again (wrap).
REQ-032 toggle in 0->1 mid-scroll coincident with tick -> next cycle "NICE" at pos=0, first advance 4 cycles later.
REQ-033 enable=0 during BLINK_OFF -> next cycle all blank, busy=0; enable=1 -> BLINK_ON, word shown next cycle.
REQ-034 assert reset asynchronously mid-scroll (between edges) -> seg all ones immediately, pos=0 after release.
